// File: rtl/write_iq.sv
// IQ writer: pops paired quantized I/Q samples, dequantizes them to saturated
// signed 16-bit values and pushes one byte-swapped packed IQ word per pair.
module write_iq #(
    parameter int QUANT_BITS = 10,
    parameter bit ROUND      = 1'b1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 inI_rd_en,
    input  logic                 inI_empty,
    input  logic [31:0]          inI_dout,
    output logic                 inQ_rd_en,
    input  logic                 inQ_empty,
    input  logic [31:0]          inQ_dout,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [31:0]          out_din,
    output logic                 sat_flag,
    output logic [CNT_WIDTH-1:0] sample_count
);

    // Two-bit encoding leaves spare codes that must recover to S_READ.
    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_WRITE = 2'd1
    } state_t;

    localparam logic signed [32:0] RND_ADD =
        ROUND ? (33'sd1 <<< (QUANT_BITS - 1)) : 33'sd0;

    // Returns {sat, value}; the 33-bit sum cannot overflow for any 32-bit input.
    function automatic logic [16:0] dequant(input logic [31:0] x);
        logic signed [32:0] r;
        logic signed [32:0] s;
        r = $signed({x[31], x}) + RND_ADD;
        s = r >>> QUANT_BITS;
        if (s > 33'sd32767) begin
            dequant = {1'b1, 16'h7FFF};
        end else if (s < -33'sd32768) begin
            dequant = {1'b1, 16'h8000};
        end else begin
            dequant = {1'b0, s[15:0]};
        end
    endfunction

    function automatic logic [31:0] pack_iq(input logic [15:0] i16, input logic [15:0] q16);
        pack_iq = {i16[7:0], i16[15:8], q16[7:0], q16[15:8]};
    endfunction

    state_t                 state_q, state_d;
    logic [15:0]            i16_q, i16_d;
    logic [15:0]            q16_q, q16_d;
    logic                   sat_q, sat_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [16:0]            deq_i;
    logic [16:0]            deq_q;

    assign deq_i        = dequant(inI_dout);
    assign deq_q        = dequant(inQ_dout);
    assign sat_flag     = sat_q;
    assign sample_count = cnt_q;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no latch is inferred.
        state_d   = state_q;
        i16_d     = i16_q;
        q16_d     = q16_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        inI_rd_en = 1'b0;
        inQ_rd_en = 1'b0;
        out_wr_en = 1'b0;
        out_din   = '0;

        case (state_q)
            S_READ: begin
                // Pop only as a pair so I and Q never drift apart.
                if (!inI_empty && !inQ_empty) begin
                    inI_rd_en = 1'b1;
                    inQ_rd_en = 1'b1;
                    i16_d     = deq_i[15:0];
                    q16_d     = deq_q[15:0];
                    sat_d     = sat_q | deq_i[16] | deq_q[16];
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    out_din   = pack_iq(i16_q, q16_q);
                    cnt_d     = cnt_q + CNT_WIDTH'(1);
                    state_d   = S_READ;
                end
            end
            default: begin
                state_d = S_READ;
                i16_d   = '0;
                q16_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_READ;
            i16_q   <= '0;
            q16_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            i16_q   <= i16_d;
            q16_q   <= q16_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
